byte_reg_bank: RTL

Parametrised successor to the single-byte register. Holds a bank of 2**ADDR_W words, each WIDTH bits wide. It has one write port with per-byte lane enables, a synchronous bank clear, and two registered read ports with write-to-read bypass. It serves as general-purpose configuration and scratch storage wherever several byte-addressable registers are needed under one clock.

---
 rtl/byte_reg_bank.sv | 67 ++++++
 1 files changed

// File: rtl/byte_reg_bank.sv
// Bank of 2**ADDR_W words with a byte-lane-masked write port, a synchronous clear,
// and two registered read ports that see a same-edge write through a bypass.
module byte_reg_bank #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wrt,
  input  logic [ADDR_W-1:0]    wrt_addr,
  input  logic [WIDTH/8-1:0]   byte_en,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 rd,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [WIDTH-1:0]     data_out_a,
  output logic [WIDTH-1:0]     data_out_b,
  output logic                 rd_valid
);

  localparam int LANES = WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_word;
  logic             hit_a;
  logic             hit_b;

  // Post-write image of the target word; feeds both the store and the read bypass.
  always_comb begin
    wr_word = mem[wrt_addr];
    for (int i = 0; i < LANES; i++) begin
      if (byte_en[i]) wr_word[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  assign hit_a = wrt && (rd_addr_a == wrt_addr);
  assign hit_b = wrt && (rd_addr_b == wrt_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_out_a <= '0;
      data_out_b <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wrt) begin
        mem[wrt_addr] <= wr_word;
      end
      // Clear wins over both stored data and any bypassed write.
      if (rd) begin
        if (clr) begin
          data_out_a <= '0;
          data_out_b <= '0;
        end else begin
          data_out_a <= hit_a ? wr_word : mem[rd_addr_a];
          data_out_b <= hit_b ? wr_word : mem[rd_addr_b];
        end
      end
    end
  end

endmodule
